// File: rtl/rotate_sequencer.sv
// Two-requester rotate sequencer: round-robin accepts 0-7 left-rotate requests and
// walks each amount through the external one-hot shifter one stage per cycle.
module rotate_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a_valid,
  output logic             req_a_ready,
  input  logic [7:0]       req_a_data,
  input  logic [2:0]       req_a_amt,
  input  logic             req_b_valid,
  output logic             req_b_ready,
  input  logic [7:0]       req_b_data,
  input  logic [2:0]       req_b_amt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_id,
  output logic [7:0]       shf_in,
  output logic [2:0]       shf_ctrl,
  input  logic [7:0]       shf_out,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [7:0]       r_work;
  logic [2:0]       r_rem;
  logic             r_res_id;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_done_cnt;

  logic       w_any_valid;
  logic       w_grant;
  logic       w_accept;
  logic [7:0] w_sel_data;
  logic [2:0] w_sel_amt;
  logic [2:0] w_stage;
  logic [2:0] w_rem_next;

  assign w_any_valid = (r_state == StIdle) && (req_a_valid || req_b_valid);

  // Grant 0 = A, 1 = B; on contention the side not served last wins.
  always_comb begin
    w_grant = 1'b0;
    if (req_a_valid && req_b_valid) begin
      w_grant = ~r_last_grant;
    end else if (req_b_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_accept    = w_any_valid;
  assign req_a_ready = w_any_valid && !w_grant;
  assign req_b_ready = w_any_valid && w_grant;
  assign w_sel_data  = w_grant ? req_b_data : req_a_data;
  assign w_sel_amt   = w_grant ? req_b_amt : req_a_amt;

  // Largest remaining stage first; one stage per RUN cycle.
  always_comb begin
    w_stage = 3'b000;
    if (r_rem[2]) begin
      w_stage = 3'b100;
    end else if (r_rem[1]) begin
      w_stage = 3'b010;
    end else if (r_rem[0]) begin
      w_stage = 3'b001;
    end
  end

  assign w_rem_next = r_rem & ~w_stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_work       <= 8'h00;
      r_rem        <= 3'b000;
      r_res_id     <= 1'b0;
      r_last_grant <= 1'b1;
      r_done_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_work       <= w_sel_data;
            r_rem        <= w_sel_amt;
            r_res_id     <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= (w_sel_amt != 3'b000) ? StRun : StDone;
          end
        end
        StRun: begin
          r_work <= shf_out;
          r_rem  <= w_rem_next;
          if (w_rem_next == 3'b000) begin
            r_state <= StDone;
          end
        end
        StDone: begin
          if (res_ready) begin
            r_done_cnt <= r_done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign shf_in    = r_work;
  assign shf_ctrl  = (r_state == StRun) ? w_stage : 3'b000;
  assign res_valid = (r_state == StDone);
  assign res_data  = r_work;
  assign res_id    = r_res_id;
  assign busy      = (r_state != StIdle);
  assign done_cnt  = r_done_cnt;

endmodule
